dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Shared data-memory arbiter between N processor cores and one single-port data memory.
- Sits directly downstream of each core's data-memory port (address, write strobe, write data) and upstream of the data RAM.
- Serialises accesses with round-robin fairness, then returns read data to the requesting core with a one-cycle valid strobe.
- Exactly one memory transaction is in flight at any time.

Parameters:
- N_CORES, 4, number of requesting cores (legal range 1..16).
- ADDR_WIDTH, 16, data-memory address width.
- DATA_WIDTH, 8, data-memory word width.
- MEM_LATENCY, 1, memory read latency in cycles: mem_rdata is valid MEM_LATENCY cycles after the mem_en cycle (legal range 1..4).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_CORES  per-core access request; held high until the matching gnt bit.
- wr  input  N_CORES  per-core write flag, qualified by req (1 = write, 0 = read).
- addr  input  N_CORES*ADDR_WIDTH  per-core address, flattened; core k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- wdata  input  N_CORES*DATA_WIDTH  per-core write data, flattened the same way.
- gnt  output  N_CORES  one-hot, one-cycle grant pulse.
- rvalid  output  N_CORES  one-hot, one-cycle read-data-valid pulse.
- rdata  output  DATA_WIDTH  read data, shared by all cores; meaningful only while some rvalid bit is high.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable; only ever high together with mem_en.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_rdata  input  DATA_WIDTH  memory read data.

Behaviour:
- Reset values:
  - state = IDLE, rr_ptr = 0.
  - gnt, rvalid, mem_en, mem_we = 0.
  - mem_addr, mem_wdata, rdata = 0.
- Reset mid-transaction aborts it: no rvalid is issued; a write already strobed to memory stands.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, cycle T:
  - If req is nonzero, select the first set bit scanning circularly upward from rr_ptr.
  - Latch that core's index, wr, addr and wdata.
  - Set rr_ptr = (idx+1) mod N_CORES.
  - Go to ISSUE.
  - If req is zero, stay in IDLE.
- ISSUE, cycle T+1:
  - mem_en = 1, mem_we = latched wr, mem_addr and mem_wdata driven from the latched values.
  - gnt[idx] = 1 for this cycle only.
  - Write: next state IDLE, so a write occupies 2 cycles.
  - Read: next state WAIT.
- WAIT, cycles T+2 .. T+1+MEM_LATENCY:
  - Count MEM_LATENCY cycles.
  - On the last WAIT cycle, capture mem_rdata into rdata.
- RESP, cycle T+2+MEM_LATENCY:
  - rvalid[idx] = 1 for this cycle only; rdata holds the captured value.
  - Next state IDLE.
  - A read occupies 3+MEM_LATENCY cycles.
- Outside ISSUE: mem_en = mem_we = 0; mem_addr and mem_wdata hold their last value.
- rdata holds its value until the next read capture.
- Arbitration is sampled only in IDLE:
  - req changes during ISSUE/WAIT/RESP are ignored.
  - A req bit dropped before its grant is simply not served.
- Requester protocol: after gnt the core deasserts req. req still high in the next IDLE counts as a new request.
- Simultaneous requests: round-robin guarantees each continuously requesting core is served within N_CORES transactions.
- N_CORES = 1: rr_ptr stays 0; arbitration degenerates to pass-through with the same timing.
- Latched addr and wdata are full width; no truncation or extension.

Test Plan:
- Single read, N_CORES=4, MEM_LATENCY=1: req=0001, wr=0, addr0=0x0010, memory returns 0x5A.
  - gnt=0001 at T+1; mem_en=1, mem_we=0, mem_addr=0x0010 at T+1.
  - rvalid=0001 with rdata=0x5A at T+3.
- Single write from core 2: req=0100, wr=0100, addr2=0x0200, wdata2=0xC3.
  - At T+1: mem_en=1, mem_we=1, mem_addr=0x0200, mem_wdata=0xC3, gnt=0100.
  - No rvalid; back in IDLE at T+2.
- Round robin: all four cores hold writes, each dropping req on its gnt.
  - Grant order is 0,1,2,3, each 2 cycles apart.
  - A second burst grants in order 0,1,2,3 again.
- Fairness: core 0 requests continuously, core 3 requests once.
  - Core 3 is granted within 2 transactions.
  - Core 0 is never granted twice in a row while core 3 is pending.
- MEM_LATENCY=3 read: rvalid asserts at T+5 with rdata equal to the mem_rdata present in the T+4 cycle.
- Reset asserted in the WAIT state of a read:
  - All outputs go to 0 on the next edge; no rvalid is issued; rr_ptr returns to 0.
  - Next request from core 1 alone is granted normally.

Source files
------------

// File: rtl/dm_arbiter.sv
// ---------------------------------------------------------------------------
// dm_arbiter
//
// Shares one single-port data memory between N_CORES processor cores.
// Requests are arbitrated round-robin while the arbiter is idle; exactly one
// memory transaction is in flight at a time. Writes take two cycles
// (select, issue). Reads take 3 + MEM_LATENCY cycles (select, issue,
// MEM_LATENCY wait cycles, response) and return data with a one-cycle
// rvalid pulse to the requesting core.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req        per-core request, held until the matching gnt bit
//   wr         per-core write flag (1 = write, 0 = read), qualified by req
//   addr       per-core address, core k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   wdata      per-core write data, core k at [k*DATA_WIDTH +: DATA_WIDTH]
//   gnt        one-hot, one-cycle grant pulse (issue cycle)
//   rvalid     one-hot, one-cycle read-data-valid pulse
//   rdata      shared read data, meaningful while any rvalid bit is high
//   mem_en     memory access strobe
//   mem_we     memory write enable, only high together with mem_en
//   mem_addr   memory address (holds its last value outside the issue cycle)
//   mem_wdata  memory write data (holds its last value outside issue)
//   mem_rdata  memory read data, valid MEM_LATENCY cycles after mem_en
//
// State table
//   state | meaning
//   IDLE  | sample req, pick a winner, latch its command
//   ISSUE | drive memory strobe and grant pulse for the latched command
//   WAIT  | count down the memory read latency, capture data on last cycle
//   RESP  | pulse rvalid to the requesting core
// ---------------------------------------------------------------------------
module dm_arbiter #(
    parameter int N_CORES     = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_CORES-1:0]               req,
    input  logic [N_CORES-1:0]               wr,
    input  logic [N_CORES*ADDR_WIDTH-1:0]    addr,
    input  logic [N_CORES*DATA_WIDTH-1:0]    wdata,
    output logic [N_CORES-1:0]               gnt,
    output logic [N_CORES-1:0]               rvalid,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             mem_en,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [DATA_WIDTH-1:0]            mem_rdata
);

    localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    // MEM_LATENCY is at most 4, so the down-counter needs to reach 3.
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        idx_q;
    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [CNT_W-1:0]        wait_cnt;

    logic                    found;
    logic [IDX_W-1:0]        sel_idx;

    // Circular index wrap; operands never exceed 2*N_CORES-2, so a single
    // conditional subtract replaces a modulo.
    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        if (v >= N_CORES) begin
            return IDX_W'(v - N_CORES);
        end
        return IDX_W'(v);
    endfunction

    // -----------------------------------------------------------------------
    // Round-robin selection: first set req bit scanning upward from rr_ptr.
    // -----------------------------------------------------------------------
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (!found && req[wrap_idx(int'(rr_ptr) + i)]) begin
                found   = 1'b1;
                sel_idx = wrap_idx(int'(rr_ptr) + i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = wr_q ? IDLE : WAIT;
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        gnt    = '0;
        rvalid = '0;
        mem_en = 1'b0;
        mem_we = 1'b0;
        case (state)
            ISSUE: begin
                gnt[idx_q] = 1'b1;
                mem_en     = 1'b1;
                mem_we     = wr_q;
            end
            RESP: begin
                rvalid[idx_q] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // The latched command registers drive the memory bus directly, so the
    // bus holds the last issued address/data until the next arbitration.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;

    // -----------------------------------------------------------------------
    // Command latch, round-robin pointer, latency timer, read capture
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            idx_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wait_cnt <= '0;
        end else begin
            if (state == IDLE && found) begin
                idx_q   <= sel_idx;
                wr_q    <= wr[sel_idx];
                addr_q  <= addr[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q <= wdata[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
                rr_ptr  <= wrap_idx(int'(sel_idx) + 1);
            end

            // Down-counter loaded in ISSUE; terminal count 0 marks the last
            // WAIT cycle, which is when mem_rdata is valid.
            if (state == ISSUE) begin
                wait_cnt <= CNT_W'(MEM_LATENCY - 1);
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end

            if (state == WAIT && wait_cnt == '0) begin
                rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Unit 0 uses MEM_LATENCY=1, unit 1 uses MEM_LATENCY=3.
    logic [N-1:0]    req       [2];
    logic [N-1:0]    wr        [2];
    logic [N*AW-1:0] addr      [2];
    logic [N*DW-1:0] wdata     [2];
    logic [N-1:0]    gnt       [2];
    logic [N-1:0]    rvalid    [2];
    logic [DW-1:0]   rdata     [2];
    logic            mem_en    [2];
    logic            mem_we    [2];
    logic [AW-1:0]   mem_addr  [2];
    logic [DW-1:0]   mem_wdata [2];
    logic [DW-1:0]   mem_rdata [2];

    dm_arbiter #(.N_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1)) u_dut0 (
        .clk(clk), .rst(rst), .req(req[0]), .wr(wr[0]), .addr(addr[0]), .wdata(wdata[0]),
        .gnt(gnt[0]), .rvalid(rvalid[0]), .rdata(rdata[0]), .mem_en(mem_en[0]),
        .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0])
    );

    dm_arbiter #(.N_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(3)) u_dut1 (
        .clk(clk), .rst(rst), .req(req[1]), .wr(wr[1]), .addr(addr[1]), .wdata(wdata[1]),
        .gnt(gnt[1]), .rvalid(rvalid[1]), .rdata(rdata[1]), .mem_en(mem_en[1]),
        .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1])
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: a transaction schedule expressed as absolute cycle
    // numbers (issue, capture, response, next free cycle) per unit.
    int            cyc = 0;
    bit            chk_en = 1'b0;
    bit            rand_mode = 1'b0;
    bit            fix_en = 1'b0;
    logic [N-1:0]  keep = '0;
    logic [N-1:0]  last_gnt [2];
    int            iss_c [2]  = '{-1, -1};
    int            cap_c [2]  = '{-1, -1};
    int            resp_c [2] = '{-1, -1};
    int            free_c [2] = '{0, 0};
    int            ptr [2]    = '{0, 0};
    int            cur_idx [2] = '{0, 0};
    bit            cur_wr [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wdata [2];
    logic [DW-1:0] m_rdata [2];
    int            gl_c [$];
    int            gl_i [$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_step();
        for (int u = 0; u < 2; u++) begin
            int lat;
            logic [N-1:0] eg;
            logic [N-1:0] ev;
            lat = (u == 0) ? 1 : 3;
            eg  = (cyc == iss_c[u])  ? N'(1 << cur_idx[u]) : '0;
            ev  = (cyc == resp_c[u]) ? N'(1 << cur_idx[u]) : '0;
            if (chk_en) begin
                chk($sformatf("u%0d c%0d gnt", u, cyc), gnt[u], eg);
                chk($sformatf("u%0d c%0d rvalid", u, cyc), rvalid[u], ev);
                chk($sformatf("u%0d c%0d mem_en", u, cyc), mem_en[u], (cyc == iss_c[u]));
                chk($sformatf("u%0d c%0d mem_we", u, cyc), mem_we[u], (cyc == iss_c[u]) && cur_wr[u]);
                chk($sformatf("u%0d c%0d mem_addr", u, cyc), mem_addr[u], m_addr[u]);
                chk($sformatf("u%0d c%0d mem_wdata", u, cyc), mem_wdata[u], m_wdata[u]);
                chk($sformatf("u%0d c%0d rdata", u, cyc), rdata[u], m_rdata[u]);
            end
            last_gnt[u] = gnt[u];
            if (u == 0 && gnt[0] != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (gnt[0][k]) begin
                        gl_c.push_back(cyc);
                        gl_i.push_back(k);
                    end
                end
            end
            if (cyc == cap_c[u]) m_rdata[u] = mem_rdata[u];
            if (rst) begin
                ptr[u] = 0; iss_c[u] = -1; cap_c[u] = -1; resp_c[u] = -1;
                free_c[u] = cyc + 1; cur_idx[u] = 0; cur_wr[u] = 1'b0;
                m_addr[u] = '0; m_wdata[u] = '0; m_rdata[u] = '0;
            end else if (cyc >= free_c[u] && req[u] != '0) begin
                int w;
                w = -1;
                for (int i = 0; i < N; i++) begin
                    if (w < 0 && req[u][(ptr[u] + i) % N]) w = (ptr[u] + i) % N;
                end
                cur_idx[u] = w;
                cur_wr[u]  = wr[u][w];
                m_addr[u]  = addr[u][w*AW +: AW];
                m_wdata[u] = wdata[u][w*DW +: DW];
                ptr[u]     = (w + 1) % N;
                iss_c[u]   = cyc + 1;
                if (cur_wr[u]) begin
                    cap_c[u] = -1; resp_c[u] = -1; free_c[u] = cyc + 2;
                end else begin
                    cap_c[u] = cyc + 1 + lat; resp_c[u] = cyc + 2 + lat; free_c[u] = cyc + 3 + lat;
                end
            end
        end
        if (rst) chk_en = 1'b1;
    endtask

    // Start of a cycle: memory data, requester behaviour (drop on grant,
    // random raise/withdraw in random mode).
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int u = 0; u < 2; u++) begin
            mem_rdata[u] = (u == 0 && fix_en) ? 8'h5A : 8'($urandom);
            for (int k = 0; k < N; k++) begin
                if (req[u][k] && last_gnt[u][k] && !keep[k] &&
                    (!rand_mode || $urandom_range(0, 7) != 0)) begin
                    req[u][k] = 1'b0;
                end else if (rand_mode) begin
                    if (!req[u][k]) begin
                        if ($urandom_range(0, 3) == 0) begin
                            req[u][k] = 1'b1;
                            wr[u][k]  = 1'($urandom_range(0, 1));
                            addr[u][k*AW +: AW]  = AW'($urandom);
                            wdata[u][k*DW +: DW] = DW'($urandom);
                        end
                    end else if ($urandom_range(0, 49) == 0) begin
                        req[u][k] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic sync();
        @(negedge clk);
        model_step();
    endtask

    task automatic cycle();
        tick();
        sync();
    endtask

    task automatic set_req(input int k, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        for (int u = 0; u < 2; u++) begin
            req[u][k] = 1'b1;
            wr[u][k]  = w;
            addr[u][k*AW +: AW]  = a;
            wdata[u][k*DW +: DW] = d;
        end
    endtask

    int t0;
    int s;
    int pos;
    logic [DW-1:0] md;

    initial begin
        for (int u = 0; u < 2; u++) begin
            req[u] = '0; wr[u] = '0; addr[u] = '0; wdata[u] = '0;
            mem_rdata[u] = '0; last_gnt[u] = '0;
        end
        rst = 1'b1;
        cycle();
        cycle();
        tick(); rst = 1'b0; sync();
        cycle();

        // Single read from core 0
        tick(); fix_en = 1'b1; set_req(0, 1'b0, 16'h0010, 8'h00); t0 = cyc; sync();
        cycle();
        chk("read gnt", gnt[0], 4'b0001);
        chk("read mem_en", mem_en[0], 1'b1);
        chk("read mem_we", mem_we[0], 1'b0);
        chk("read mem_addr", mem_addr[0], 16'h0010);
        cycle(); cycle();
        chk("read rvalid", rvalid[0], 4'b0001);
        chk("read rdata", rdata[0], 8'h5A);
        cycle();
        md = mem_rdata[1];
        cycle();
        chk("lat3 rvalid", rvalid[1], 4'b0001);
        chk("lat3 rdata", rdata[1], md);
        tick(); fix_en = 1'b0; sync();
        repeat (3) cycle();

        // Single write from core 2
        tick(); set_req(2, 1'b1, 16'h0200, 8'hC3); sync();
        cycle();
        chk("write gnt", gnt[0], 4'b0100);
        chk("write mem_en", mem_en[0], 1'b1);
        chk("write mem_we", mem_we[0], 1'b1);
        chk("write mem_addr", mem_addr[0], 16'h0200);
        chk("write mem_wdata", mem_wdata[0], 8'hC3);
        cycle();
        chk("write done mem_en", mem_en[0], 1'b0);
        chk("write hold mem_addr", mem_addr[0], 16'h0200);
        cycle();
        chk("write no rvalid", rvalid[0], 4'b0000);
        repeat (2) cycle();

        // Round robin: two bursts of four writes after a reset
        tick(); rst = 1'b1; sync();
        tick(); rst = 1'b0; sync();
        for (int b = 0; b < 2; b++) begin
            s = gl_i.size();
            tick();
            for (int k = 0; k < N; k++) set_req(k, 1'b1, AW'(16'h0100 + k), DW'(8'h10 + k));
            t0 = cyc;
            sync();
            repeat (10) cycle();
            chk($sformatf("rr%0d count", b), gl_i.size() - s, 4);
            if (gl_i.size() >= s + 4) begin
                for (int j = 0; j < 4; j++) begin
                    chk($sformatf("rr%0d idx%0d", b, j), gl_i[s+j], j);
                    chk($sformatf("rr%0d time%0d", b, j), gl_c[s+j] - t0, 1 + 2*j);
                end
            end
        end

        // Fairness: core 0 continuous, core 3 once
        s = gl_i.size();
        tick(); keep = 4'b0001;
        set_req(0, 1'b1, 16'h0333, 8'h33);
        set_req(3, 1'b1, 16'h0444, 8'h44);
        sync();
        repeat (8) cycle();
        tick(); keep = '0; req[0][0] = 1'b0; req[1][0] = 1'b0; sync();
        repeat (6) cycle();
        pos = -1;
        for (int j = s; j < gl_i.size(); j++) begin
            if (pos < 0 && gl_i[j] == 3) pos = j - s;
        end
        chk("fair core3 position", pos, 1);
        chk("fair first", (gl_i.size() > s) ? gl_i[s] : -1, 0);
        chk("fair core0 resumes", (gl_i.size() > s + 2) ? gl_i[s+2] : -1, 0);

        // Reset in WAIT of a read from core 2
        tick(); set_req(2, 1'b0, 16'h0ABC, 8'h00); sync();
        cycle();
        tick(); rst = 1'b1; sync();
        tick(); rst = 1'b0; sync();
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("rst u%0d gnt", u), gnt[u], 4'b0000);
            chk($sformatf("rst u%0d rvalid", u), rvalid[u], 4'b0000);
            chk($sformatf("rst u%0d mem_en", u), mem_en[u], 1'b0);
            chk($sformatf("rst u%0d mem_addr", u), mem_addr[u], 16'h0000);
            chk($sformatf("rst u%0d rdata", u), rdata[u], 8'h00);
        end
        tick(); set_req(1, 1'b0, 16'h0111, 8'h00); set_req(3, 1'b0, 16'h0333, 8'h00); sync();
        cycle();
        chk("post-rst u0 gnt", gnt[0], 4'b0010);
        chk("post-rst u1 gnt", gnt[1], 4'b0010);
        chk("post-rst u1 no rvalid", rvalid[1], 4'b0000);
        repeat (16) cycle();

        // Randomized traffic with occasional resets
        tick(); rand_mode = 1'b1; sync();
        repeat (3000) begin
            tick();
            rst = ($urandom_range(0, 399) == 0);
            sync();
        end
        tick(); rst = 1'b0; rand_mode = 1'b0; req[0] = '0; req[1] = '0; sync();
        repeat (20) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
